int8_32x32_requant: RTL and testbench
=====================================

// Module: int8_32x32_requant
// PURPOSE
//  Downstream stage of the 32x32 int8 tensor-slice matrix-multiply wrapper.
//  Consumes its AXI-Stream of 32 result rows (512-bit, 32 x int16 lanes) and requantizes each lane to int8.
//  Per-lane operation: scale multiply, rounding right-shift, zero-point add, saturate.
//  Emits 32 packed 256-bit rows for the next layer's A-matrix stream; ap_ctrl_hs-style block control.
// PARAMETERS
//  ROWS     32  rows per matrix (transfers per ap_start)
//  LANES    32  elements per row
//  IN_W     16  signed input lane width (LANES*IN_W = 512)
//  OUT_W    8   signed output lane width (LANES*OUT_W = 256)
// PORTS
//  ap_clk       in   1    sole clock; all logic rising-edge
//  ap_rst_n     in   1    asynchronous, active-low reset
//  ap_start     in   1    begin one matrix; sampled in IDLE only
//  ap_done      out  1    high in DONE until ap_continue
//  ap_idle      out  1    high in IDLE
//  ap_ready     out  1    high in IDLE
//  ap_continue  in   1    DONE -> IDLE acknowledge
//  scale        in   16   unsigned multiplier; latched at start
//  shift        in   5    right-shift amount 0..31; latched at start
//  zero_point   in   8    signed int8 offset; latched at start
//  c_tdata      in   512  input row; lane k = bits [16k+15:16k]
//  c_tvalid     in   1    input valid
//  c_tready     out  1    input ready
//  q_tdata      out  256  output row; lane k = bits [8k+7:8k]
//  q_tvalid     out  1    output valid
//  q_tready     in   1    output ready
//  q_tlast      out  1    high with row ROWS-1
//  sat_flag     out  1    sticky: any lane saturated this matrix
// BEHAVIOUR
//  Reset (ap_rst_n=0, async): state=IDLE; outputs ap_done=0, ap_idle=1, ap_ready=1, c_tready=0,
//   q_tvalid=0, q_tlast=0, q_tdata=0, sat_flag=0; all pipeline valids cleared, counters=0.
//   Reset mid-matrix discards in-flight data; no partial output is emitted after release.
//  FSM states:
//   IDLE --ap_start--> RUN. Latches scale/shift/zero_point, clears sat_flag and both row counters.
//   RUN: accepts rows. After ROWS inputs accepted -> DRAIN.
//   DRAIN: c_tready=0. After the ROWS-th output handshake -> DONE.
//   DONE: ap_done=1 --ap_continue--> IDLE. c_tvalid is ignored outside RUN.
//  Pipeline: 3 stages (S1 multiply, S2 round/shift/zp/saturate, S3 = q_* output register).
//   Global advance en = !q_tvalid | q_tready.
//   c_tready = (state==RUN) & en & (in_cnt<ROWS).
//   Latency: input handshake at cycle t -> q_tvalid at t+3 when no backpressure.
//   Throughput: 1 row/cycle under continuous valid/ready.
//   Stall: all stages hold; q_tdata stays stable while q_tvalid & !q_tready. No bubbles are inserted or dropped.
//  Arithmetic per lane (c signed 16b):
//   p = c * {1'b0,scale}                       -> 33-bit signed.
//   r = (p + (shift ? 1<<(shift-1) : 0)) >>> shift  -> 34-bit signed, round-half-up.
//   v = r + sext(zero_point).
//   q = v>127 ? 127 : v<-128 ? -128 : v[7:0].
//   sat_flag |= any lane clamped, on S2 advance.
//  Counters: in_cnt counts c handshakes; out_cnt counts q handshakes; both 6-bit, 0..ROWS, no wrap.
//   q_tlast = q_tvalid & (row in S3 is index ROWS-1).
//  Boundaries:
//   Input and output handshake in the same cycle are both counted.
//   The ROWS-th input enters DRAIN even if q is stalled.
//   ap_start high in RUN/DRAIN/DONE is ignored.
//   scale=0 gives q = sat(zero_point).
//   shift=0 gives no rounding term.
// TESTING
//  Identity: scale=1, shift=0, zp=0; lane k of row r = r*32+k-512 ->
//   q = clamp of the same value; sat_flag=1 (values below -128); q_tlast only on row 31.
//  Rounding: scale=3, shift=2, zp=0; lanes {5,-5,6,-6,2,-2} ->
//   q = {4,-4,5,-4,2,-1}; sat_flag=0.
//  Zero point/saturate: scale=256, shift=4, zp=-10; lanes {100,-100,8,0} ->
//   q = {127,-128,118,-10}; sat_flag=1.
//  Backpressure: q_tready toggles 1010..., c_tvalid random ->
//   exactly 32 outputs in order; q_tdata stable while stalled; first output 3 cycles after first input.
//  Control: ap_done held through 5 cycles of ap_continue=0, then IDLE.
//   Second ap_start with new scale -> new scale applied and sat_flag cleared.
//  Reset mid-run: assert ap_rst_n=0 after 10 rows ->
//   immediately q_tvalid=0, ap_idle=1; a fresh 32-row run after release is correct.

Source files
------------

// File: rtl/int8_32x32_requant.sv
// Requantizes ROWS x LANES int16 rows to int8 (scale, round-half-up shift, zero point, saturate); 3-cycle latency.
// One global enable stalls every stage while q_tvalid & !q_tready, so q_* holds stable and no bubbles are added or lost.
module int8_32x32_requant #(
  parameter int ROWS  = 32,
  parameter int LANES = 32,
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     ap_start,
  output logic                     ap_done,
  output logic                     ap_idle,
  output logic                     ap_ready,
  input  logic                     ap_continue,
  input  logic [15:0]              scale,
  input  logic [4:0]               shift,
  input  logic [OUT_W-1:0]         zero_point,
  input  logic [LANES*IN_W-1:0]    c_tdata,
  input  logic                     c_tvalid,
  output logic                     c_tready,
  output logic [LANES*OUT_W-1:0]   q_tdata,
  output logic                     q_tvalid,
  input  logic                     q_tready,
  output logic                     q_tlast,
  output logic                     sat_flag
);

  localparam int PW = IN_W + 17;
  localparam int RW = PW + 1;
  localparam int VW = RW + 1;
  localparam logic signed [VW-1:0] QMAX = VW'(2**(OUT_W-1) - 1);
  localparam logic signed [VW-1:0] QMIN = VW'(-(2**(OUT_W-1)));
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
  localparam logic [5:0] NUM_ROWS = 6'(ROWS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state;
  logic [15:0]             scale_r;
  logic [4:0]              shift_r;
  logic signed [OUT_W-1:0] zp_r;
  logic [5:0]              in_cnt;
  logic [5:0]              out_cnt;
  logic                    en;
  logic                    c_hs;
  logic                    q_hs;

  logic                    s1_vld;
  logic                    s1_last;
  logic signed [PW-1:0]    s1_p [LANES];
  logic signed [PW-1:0]    prod [LANES];

  logic                    s2_vld;
  logic                    s2_last;
  logic [LANES*OUT_W-1:0]  s2_q;
  logic [LANES*OUT_W-1:0]  s2_d;
  logic                    s2_sat_d;

  logic signed [RW-1:0]    rnd;
  logic signed [RW-1:0]    r_l;
  logic signed [VW-1:0]    v_l;

  assign en       = !q_tvalid || q_tready;
  assign c_tready = (state == S_RUN) && en && (in_cnt < NUM_ROWS);
  assign c_hs     = c_tvalid && c_tready;
  assign q_hs     = q_tvalid && q_tready;
  assign ap_idle  = (state == S_IDLE);
  assign ap_ready = (state == S_IDLE);
  assign ap_done  = (state == S_DONE);

  assign rnd = (shift_r == 5'd0) ? '0 : (RW'(1) << (shift_r - 5'd1));

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod[k] = PW'($signed(c_tdata[IN_W*k +: IN_W])) * PW'($signed({1'b0, scale_r}));
    end
  end

  always_comb begin
    s2_d     = '0;
    s2_sat_d = 1'b0;
    r_l      = '0;
    v_l      = '0;
    for (int k = 0; k < LANES; k++) begin
      r_l = (RW'(s1_p[k]) + rnd) >>> shift_r;
      v_l = VW'(r_l) + VW'(zp_r);
      if (v_l > QMAX) begin
        s2_d[OUT_W*k +: OUT_W] = QMAX[OUT_W-1:0];
        s2_sat_d = 1'b1;
      end else if (v_l < QMIN) begin
        s2_d[OUT_W*k +: OUT_W] = QMIN[OUT_W-1:0];
        s2_sat_d = 1'b1;
      end else begin
        s2_d[OUT_W*k +: OUT_W] = v_l[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= S_IDLE;
      scale_r  <= '0;
      shift_r  <= '0;
      zp_r     <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      sat_flag <= 1'b0;
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      for (int k = 0; k < LANES; k++) s1_p[k] <= '0;
      s2_vld   <= 1'b0;
      s2_last  <= 1'b0;
      s2_q     <= '0;
      q_tvalid <= 1'b0;
      q_tlast  <= 1'b0;
      q_tdata  <= '0;
    end else begin
      case (state)
        S_IDLE:  if (ap_start) state <= S_RUN;
        S_RUN:   if (c_hs && in_cnt == LAST_ROW) state <= S_DRAIN;
        S_DRAIN: if (q_hs && out_cnt == LAST_ROW) state <= S_DONE;
        default: if (ap_continue) state <= S_IDLE;
      endcase

      if (state == S_IDLE && ap_start) begin
        scale_r <= scale;
        shift_r <= shift;
        zp_r    <= zero_point;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (c_hs) in_cnt <= in_cnt + 6'd1;
        if (q_hs && (state == S_RUN || state == S_DRAIN) && out_cnt < NUM_ROWS)
          out_cnt <= out_cnt + 6'd1;
      end

      // sat_flag accumulates only for rows actually moving out of S1
      if (state == S_IDLE && ap_start) sat_flag <= 1'b0;
      else if (en && s1_vld && s2_sat_d) sat_flag <= 1'b1;

      if (en) begin
        s1_vld  <= c_hs;
        s1_last <= (in_cnt == LAST_ROW);
        for (int k = 0; k < LANES; k++) s1_p[k] <= prod[k];
        s2_vld   <= s1_vld;
        s2_last  <= s1_last;
        s2_q     <= s2_d;
        q_tvalid <= s2_vld;
        q_tlast  <= s2_vld && s2_last;
        q_tdata  <= s2_q;
      end
    end
  end

endmodule

// File: tb/tb_int8_32x32_requant.sv
// Directed bench for int8_32x32_requant: identity, rounding, zero point/saturation, backpressure, control and reset.
module tb_int8_32x32_requant;
  localparam int ROWS  = 32;
  localparam int LANES = 32;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         ap_start = 1'b0;
  logic         ap_done, ap_idle, ap_ready;
  logic         ap_continue = 1'b0;
  logic [15:0]  scale = '0;
  logic [4:0]   shift = '0;
  logic [7:0]   zero_point = '0;
  logic [511:0] c_tdata = '0;
  logic         c_tvalid = 1'b0;
  logic         c_tready;
  logic [255:0] q_tdata;
  logic         q_tvalid;
  logic         q_tready = 1'b0;
  logic         q_tlast;
  logic         sat_flag;

  logic [511:0] in_rows  [ROWS];
  logic [255:0] exp_rows [ROWS];

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  int8_32x32_requant dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_continue(ap_continue),
    .scale(scale), .shift(shift), .zero_point(zero_point),
    .c_tdata(c_tdata), .c_tvalid(c_tvalid), .c_tready(c_tready),
    .q_tdata(q_tdata), .q_tvalid(q_tvalid), .q_tready(q_tready),
    .q_tlast(q_tlast), .sat_flag(sat_flag)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // lane k of row r = r*32+k-512, expected is the same value clamped to int8
  task automatic load_identity();
    int v, e;
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < LANES; k++) begin
        v = r * 32 + k - 512;
        e = (v > 127) ? 127 : (v < -128) ? -128 : v;
        in_rows[r][16*k +: 16] = 16'(v);
        exp_rows[r][8*k +: 8]  = 8'(e);
      end
    end
  endtask

  // scale=3 shift=2 zp=0: pattern slides across lanes row by row, other lanes 0 -> 0
  task automatic load_rounding();
    int ci [6] = '{5, -5, 6, -6, 2, -2};
    int qe [6] = '{4, -4, 5, -4, 2, -1};
    for (int r = 0; r < ROWS; r++) begin
      in_rows[r] = '0;
      exp_rows[r] = '0;
      for (int j = 0; j < 6; j++) begin
        in_rows[r][16*((r % 26) + j) +: 16] = 16'(ci[j]);
        exp_rows[r][8*((r % 26) + j) +: 8]  = 8'(qe[j]);
      end
    end
  endtask

  // scale=256 shift=4 zp=-10: zero lanes land on -10
  task automatic load_zp();
    int ci [4] = '{100, -100, 8, 0};
    int qe [4] = '{127, -128, 118, -10};
    for (int r = 0; r < ROWS; r++) begin
      in_rows[r] = '0;
      for (int k = 0; k < LANES; k++) exp_rows[r][8*k +: 8] = 8'(-10);
      for (int j = 0; j < 4; j++) begin
        in_rows[r][16*((r % 28) + j) +: 16] = 16'(ci[j]);
        exp_rows[r][8*((r % 28) + j) +: 8]  = 8'(qe[j]);
      end
    end
  endtask

  task automatic start(input logic [15:0] sc, input logic [4:0] sh, input logic [7:0] zp,
                       input logic hold_start);
    @(negedge ap_clk);
    scale = sc; shift = sh; zero_point = zp; ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = hold_start;
    scale = 16'h0;
    shift = 5'd31;
    zero_point = 8'h55;
    #1;
    check("started", 256'(ap_idle), 256'd0);
  endtask

  // mode 0: always valid/ready; mode 1: random c_tvalid, q_tready 1010...
  task automatic run_matrix(input int mode, input int abort_at);
    int in_idx = 0, out_idx = 0, cyc = 0, first_in = -1, first_vld = -1;
    logic stalled = 1'b0;
    logic [255:0] held = '0;
    while (!ap_done && cyc < 3000) begin
      @(negedge ap_clk);
      c_tvalid = (in_idx < ROWS) && (mode == 0 || $urandom_range(0, 1) == 1);
      if (in_idx < ROWS) c_tdata = in_rows[in_idx];
      else c_tdata = '0;
      q_tready = (mode == 0) || (cyc % 2 == 0);
      #1;
      if (stalled) begin
        check("stall_vld", 256'(q_tvalid), 256'd1);
        check("stall_dat", q_tdata, held);
      end
      stalled = q_tvalid && !q_tready;
      held = q_tdata;
      if (q_tvalid && first_vld < 0) first_vld = cyc;
      if (c_tvalid && c_tready) begin
        if (first_in < 0) first_in = cyc;
        in_idx++;
      end
      if (q_tvalid && q_tready) begin
        if (out_idx < ROWS) begin
          check($sformatf("row%0d", out_idx), q_tdata, exp_rows[out_idx]);
          check($sformatf("tlast%0d", out_idx), 256'(q_tlast), 256'(out_idx == ROWS - 1));
        end else begin
          check("extra_out", 256'(out_idx), 256'(ROWS - 1));
        end
        out_idx++;
      end
      cyc++;
      if (abort_at > 0 && in_idx == abort_at) break;
    end
    c_tvalid = 1'b0;
    if (abort_at == 0) begin
      check("timeout", 256'(ap_done), 256'd1);
      check("in_count", 256'(in_idx), 256'(ROWS));
      check("out_count", 256'(out_idx), 256'(ROWS));
      check("latency", 256'(first_vld - first_in), 256'd3);
    end else begin
      check("abort_reached", 256'(in_idx), 256'(abort_at));
    end
  endtask

  task automatic finish_matrix(input int hold, input logic exp_sat);
    check("sat_flag", 256'(sat_flag), 256'(exp_sat));
    for (int i = 0; i < hold; i++) begin
      @(negedge ap_clk); #1;
      check("done_hold", 256'(ap_done), 256'd1);
      check("not_idle", 256'(ap_idle), 256'd0);
    end
    @(negedge ap_clk);
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    #1;
    check("back_idle", 256'(ap_idle), 256'd1);
    check("done_clr", 256'(ap_done), 256'd0);
  endtask

  initial begin
    #1;
    check("rst_idle", 256'(ap_idle), 256'd1);
    check("rst_ready", 256'(ap_ready), 256'd1);
    check("rst_done", 256'(ap_done), 256'd0);
    check("rst_ctready", 256'(c_tready), 256'd0);
    check("rst_qvalid", 256'(q_tvalid), 256'd0);
    check("rst_qlast", 256'(q_tlast), 256'd0);
    check("rst_qdata", q_tdata, 256'd0);
    check("rst_sat", 256'(sat_flag), 256'd0);
    #20 ap_rst_n = 1'b1;

    load_identity();
    start(16'd1, 5'd0, 8'd0, 1'b0);
    run_matrix(0, 0);
    finish_matrix(5, 1'b1);

    load_zp();
    start(16'd256, 5'd4, 8'hF6, 1'b1);
    run_matrix(0, 0);
    ap_start = 1'b0;
    finish_matrix(1, 1'b1);

    load_rounding();
    start(16'd3, 5'd2, 8'd0, 1'b0);
    run_matrix(0, 0);
    finish_matrix(1, 1'b0);

    load_identity();
    start(16'd1, 5'd0, 8'd0, 1'b0);
    run_matrix(1, 0);
    finish_matrix(1, 1'b1);

    start(16'd1, 5'd0, 8'd0, 1'b0);
    run_matrix(0, 10);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    check("midrst_qvalid", 256'(q_tvalid), 256'd0);
    check("midrst_idle", 256'(ap_idle), 256'd1);
    check("midrst_sat", 256'(sat_flag), 256'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    load_rounding();
    start(16'd3, 5'd2, 8'd0, 1'b0);
    run_matrix(0, 0);
    finish_matrix(1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
